// File: rtl/apb_master_arbiter.sv
// Round-robin APB4 master sharing one APB slave between NREQ valid/done requesters.
// Sequences SETUP/ACCESS, returns read data and aborts slaves that stall past TIMEOUT.
module apb_master_arbiter #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned NBYTES     = DATA_WIDTH / 8,
   parameter int unsigned NREQ       = 2,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                       PCLK,
   input  logic                       PRESETn,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NREQ-1:0]            req_write,
   input  logic [NREQ*NBYTES-1:0]     req_strb,
   input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NREQ-1:0]            req_done,
   output logic [NREQ-1:0]            req_err,
   output logic [NREQ*DATA_WIDTH-1:0] req_rdata,
   output logic                       PSELx,
   output logic                       PENABLE,
   output logic [ADDR_WIDTH-1:0]      PADDR,
   output logic                       PWRITE,
   output logic [NBYTES-1:0]          PSTRB,
   output logic [DATA_WIDTH-1:0]      PWDATA,
   input  logic [DATA_WIDTH-1:0]      PRDATA,
   input  logic                       PREADY
);

   localparam int unsigned GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e                       r_state, w_state;
   logic [CW-1:0]                r_cnt, w_cnt;
   logic [GW-1:0]                r_last, w_last;
   logic                         r_psel, w_psel;
   logic                         r_penable, w_penable;
   logic [ADDR_WIDTH-1:0]        r_paddr, w_paddr;
   logic                         r_pwrite, w_pwrite;
   logic [NBYTES-1:0]            r_pstrb, w_pstrb;
   logic [DATA_WIDTH-1:0]        r_pwdata, w_pwdata;
   logic [NREQ-1:0]              r_done, w_done;
   logic [NREQ-1:0]              r_err, w_err;
   logic [NREQ*DATA_WIDTH-1:0]   r_rdata, w_rdata;

   logic [NREQ-1:0]              w_elig;
   logic                         w_found;
   logic [GW-1:0]                w_gnt;
   logic [GW-1:0]                w_idx;

   // A requester whose done pulse is visible still holds a stale valid this cycle.
   assign w_elig = req_valid & ~r_done;

   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         w_idx = GW'((int'(r_last) + k) % NREQ);
         if (!w_found && w_elig[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
         end
      end
   end

   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_last    = r_last;
      w_psel    = r_psel;
      w_penable = r_penable;
      w_paddr   = r_paddr;
      w_pwrite  = r_pwrite;
      w_pstrb   = r_pstrb;
      w_pwdata  = r_pwdata;
      w_done    = '0;
      w_err     = '0;
      w_rdata   = r_rdata;
      unique case (r_state)
         StIdle: begin
            if (w_found) begin
               w_last    = w_gnt;
               w_paddr   = req_addr[int'(w_gnt)*ADDR_WIDTH +: ADDR_WIDTH];
               w_pwrite  = req_write[w_gnt];
               w_pwdata  = req_wdata[int'(w_gnt)*DATA_WIDTH +: DATA_WIDTH];
               w_pstrb   = req_write[w_gnt] ? req_strb[int'(w_gnt)*NBYTES +: NBYTES] : '0;
               w_psel    = 1'b1;
               w_penable = 1'b0;
               w_state   = StSetup;
            end
         end
         StSetup: begin
            w_penable = 1'b1;
            w_cnt     = '0;
            w_state   = StAccess;
         end
         StAccess: begin
            if (PREADY) begin
               w_psel         = 1'b0;
               w_penable      = 1'b0;
               w_done[r_last] = 1'b1;
               if (!r_pwrite) begin
                  w_rdata[int'(r_last)*DATA_WIDTH +: DATA_WIDTH] = PRDATA;
               end
               w_state = StIdle;
            end else begin
               w_cnt = r_cnt + 1'b1;
               if (w_cnt == CW'(TIMEOUT)) begin
                  w_psel         = 1'b0;
                  w_penable      = 1'b0;
                  w_done[r_last] = 1'b1;
                  w_err[r_last]  = 1'b1;
                  w_state        = StIdle;
               end
            end
         end
         default: w_state = StIdle;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_last    <= GW'(NREQ - 1);
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_paddr   <= '0;
         r_pwrite  <= 1'b0;
         r_pstrb   <= '0;
         r_pwdata  <= '0;
         r_done    <= '0;
         r_err     <= '0;
         r_rdata   <= '0;
      end else begin
         r_state   <= w_state;
         r_cnt     <= w_cnt;
         r_last    <= w_last;
         r_psel    <= w_psel;
         r_penable <= w_penable;
         r_paddr   <= w_paddr;
         r_pwrite  <= w_pwrite;
         r_pstrb   <= w_pstrb;
         r_pwdata  <= w_pwdata;
         r_done    <= w_done;
         r_err     <= w_err;
         r_rdata   <= w_rdata;
      end
   end

   assign PSELx     = r_psel;
   assign PENABLE   = r_penable;
   assign PADDR     = r_paddr;
   assign PWRITE    = r_pwrite;
   assign PSTRB     = r_pstrb;
   assign PWDATA    = r_pwdata;
   assign req_done  = r_done;
   assign req_err   = r_err;
   assign req_rdata = r_rdata;

endmodule
